// File: rtl/fp_norm_round.sv
// FP adder normalise/round stage: left-normalises the raw sum,
// rounds to nearest-even and packs an IEEE single. Option: FP_NORM_LZC_EN.
module fp_norm_round #(
  parameter int EW        = 8,
  parameter int MAX_SHIFT = 27
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   ncase_in,
  input  logic          special_in,
  input  logic          sign_in,
  input  logic [27:0]   mant_in,
  input  logic [EW-1:0] exp_in,
  input  logic          carry_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   result,
  output logic          overflow,
  output logic          underflow,
  output logic          inexact
);

  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] LONE = XW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    OUT
  } state_t;

  state_t                r_state;
  logic [27:0]           r_mant;
  logic signed [XW-1:0]  r_exp;
  logic                  r_sign;
  logic                  r_sub;
  logic                  r_out_valid;
  logic [31:0]           r_result;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_inexact;

  logic [27:0]           w_carry_m;
  logic signed [XW-1:0]  w_exp_in;
  logic                  w_g;
  logic                  w_s;
  logic                  w_inc;
  logic [24:0]           w_r25;
  logic [22:0]           w_frac;
  logic signed [XW-1:0]  w_exp_rnd;
  logic                  w_promote;
  logic                  w_still_sub;
  logic [7:0]            w_fld;
  logic                  w_inx;
  logic                  w_ovf;

  assign w_carry_m = {1'b1, mant_in[27:2], mant_in[1] | mant_in[0]};
  assign w_exp_in  = $signed({2'b00, exp_in});

  assign w_g       = r_mant[3];
  assign w_s       = |r_mant[2:0];
  assign w_inc     = w_g & (w_s | r_mant[4]);
  assign w_r25     = {1'b0, r_mant[27:4]} + {24'd0, w_inc};
  assign w_frac    = w_r25[24] ? w_r25[23:1] : w_r25[22:0];
  assign w_exp_rnd = r_exp + $signed({{(XW-1){1'b0}}, w_r25[24]});
  assign w_promote = r_sub & w_r25[23];
  assign w_still_sub = r_sub & ~w_r25[23];
  assign w_fld     = w_still_sub ? 8'h00 :
                     w_promote   ? 8'h01 : w_exp_rnd[7:0];
  assign w_inx     = w_g | w_s;
  assign w_ovf     = ~r_sub & (w_exp_rnd >= 255);

`ifdef FP_NORM_LZC_EN
  logic [4:0]            w_lz;
  logic [4:0]            w_sh;
  logic [EW-1:0]         w_lim;
  logic [27:0]           w_shm;
  logic signed [XW-1:0]  w_she;

  // Leading-zero count with the shift clamped so the exponent stays >= 1
  always_comb begin
    w_lz = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (mant_in[i]) w_lz = 5'(27 - i);
    end
    w_lim = (exp_in > 1) ? exp_in - 1'b1 : '0;
    w_sh  = w_lz;
    if ({{(EW-5){1'b0}}, w_lz} > w_lim) w_sh = w_lim[4:0];
    w_shm = mant_in << w_sh;
    w_she = w_exp_in - $signed({{(XW-5){1'b0}}, w_sh});
  end
`else
  localparam int CW = $clog2(MAX_SHIFT + 1);
  logic [CW-1:0]         r_cnt;
`endif

  // Control FSM: accept, normalise, round, then hold output until taken
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
`ifndef FP_NORM_LZC_EN
      r_cnt       <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= sign_in;
            r_sub  <= 1'b0;
`ifndef FP_NORM_LZC_EN
            r_cnt  <= '0;
`endif
            if (special_in) begin
              r_result    <= ncase_in;
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
              r_inexact   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= OUT;
            end else if (carry_in) begin
              r_mant  <= w_carry_m;
              r_exp   <= w_exp_in + LONE;
              r_state <= ROUND;
            end else if (mant_in == '0) begin
              r_result    <= {sign_in, 31'd0};
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
              r_inexact   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= OUT;
            end else if (mant_in[27]) begin
              r_mant  <= mant_in;
              r_exp   <= w_exp_in;
              r_state <= ROUND;
            end else begin
`ifdef FP_NORM_LZC_EN
              r_mant  <= w_shm;
              r_exp   <= w_she;
              r_sub   <= ~w_shm[27];
              r_state <= ROUND;
`else
              r_mant  <= mant_in;
              r_exp   <= w_exp_in;
              r_state <= SHIFT;
`endif
            end
          end
        end
        SHIFT: begin
`ifdef FP_NORM_LZC_EN
          r_state <= ROUND;
`else
          if (r_mant[27]) begin
            r_state <= ROUND;
          end else if (r_cnt == CW'(MAX_SHIFT)) begin
            r_sub   <= 1'b1;
            r_state <= ROUND;
          end else if (r_exp > 1) begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - LONE;
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            r_sub   <= 1'b1;
            r_state <= ROUND;
          end
`endif
        end
        ROUND: begin
          r_inexact   <= w_inx;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
          if (w_ovf) begin
            r_result    <= {r_sign, 8'hFF, 23'd0};
            r_overflow  <= 1'b1;
            r_underflow <= 1'b0;
          end else begin
            r_result    <= {r_sign, w_fld, w_frac};
            r_overflow  <= 1'b0;
            r_underflow <= w_still_sub & w_inx;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign inexact   = r_inexact;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: arithmetic reference model, directed
// vectors with literal pins, and a per-cycle output checker.
module tb_fp_norm_round;

`ifdef FP_NORM_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ncase_in;
  logic        special_in;
  logic        sign_in;
  logic [27:0] mant_in;
  logic [7:0]  exp_in;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  fp_norm_round #(.EW(8), .MAX_SHIFT(27)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ncase_in(ncase_in), .special_in(special_in),
    .sign_in(sign_in), .mant_in(mant_in),
    .exp_in(exp_in), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic        exp_pending = 1'b0;
  logic [31:0] exp_res;
  logic        exp_ovf, exp_unf, exp_inx;
  int          exp_lat;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: exact value sig * 2^k, normalise, round-half-even
  function automatic void model(
    input logic sp, input logic [31:0] nc, input logic sg,
    input logic [27:0] m, input logic [7:0] ex, input logic cy,
    output logic [31:0] res, output logic ov, output logic un,
    output logic ix, output int lat);
    longint sig, keep, rem, half;
    int e, nb, s, fld;
    ov = 0; un = 0; ix = 0;
    if (sp) begin
      res = nc; lat = 0; return;
    end
    if (!cy && m == 0) begin
      res = {sg, 31'd0}; lat = 0; return;
    end
    if (cy) begin
      sig = (64'd1 << 28) | 64'(m);
      nb = 29; e = int'(ex) + 1; lat = 1;
    end else begin
      sig = 64'(m); nb = 28; e = int'(ex); s = 0;
      while (((sig >> 27) & 1) == 0 && e > 1) begin
        sig = sig << 1; e--; s++;
      end
      lat = m[27] ? 1 : (LZC ? 1 : s + 2);
    end
    keep = sig >> (nb - 24);
    rem  = sig & ((64'd1 << (nb - 24)) - 1);
    half = 64'd1 << (nb - 25);
    if (rem > half || (rem == half && (keep & 1) == 1)) keep++;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1; e++;
    end
    ix = (rem != 0);
    if (keep >= (64'd1 << 23)) fld = (e < 1) ? 1 : e;
    else fld = 0;
    if (fld >= 255) begin
      res = {sg, 8'hFF, 23'd0}; ov = 1;
    end else begin
      res = {sg, 8'(fld), 23'(keep)};
      un = (fld == 0) && ix;
    end
  endfunction

  // Output checker: every valid cycle against the pending expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid) begin
      if (!exp_pending) begin
        chk("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!prev_valid)
          chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        chk("result", 64'(result), 64'(exp_res));
        chk("flags", {61'd0, overflow, underflow, inexact},
            {61'd0, exp_ovf, exp_unf, exp_inx});
      end
    end
    prev_valid = (reset === 1'b1) && out_valid;
  end

  task automatic pin(input string nm, input logic sp,
                     input logic [31:0] nc, input logic sg,
                     input logic [27:0] m, input logic [7:0] ex,
                     input logic cy, input logic [31:0] eres,
                     input logic [2:0] ef, input int elat);
    logic [31:0] r;
    logic o, u, x;
    int l;
    model(sp, nc, sg, m, ex, cy, r, o, u, x, l);
    chk({nm, "_res"}, 64'(r), 64'(eres));
    chk({nm, "_flg_lat"}, {29'd0, o, u, x, l}, {29'd0, ef, elat});
  endtask

  task automatic send(input logic sp, input logic [31:0] nc,
                      input logic sg, input logic [27:0] m,
                      input logic [7:0] ex, input logic cy,
                      input int hold);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk); t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    model(sp, nc, sg, m, ex, cy, exp_res, exp_ovf, exp_unf,
          exp_inx, exp_lat);
    exp_pending = 1'b1;
    acc_cyc = cyc + 1;
    special_in = sp; ncase_in = nc; sign_in = sg;
    mant_in = m; exp_in = ex; carry_in = cy;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk); t++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_hold", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    t = 0;
    while (out_valid && t < 100) begin
      @(negedge clk); t++;
    end
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    exp_pending = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] rm;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ncase_in = '0; special_in = 1'b0; sign_in = 1'b0;
    mant_in = '0; exp_in = '0; carry_in = 1'b0;

    pin("p_carry3", 0, 0, 0, 28'h8000000, 8'd127, 1,
        32'h40400000, 3'b000, 1);
    pin("p_carry2", 0, 0, 0, 28'h0000000, 8'd127, 1,
        32'h40000000, 3'b000, 1);
    pin("p_shift4", 0, 0, 0, 28'h0800000, 8'd130, 0,
        32'h3F000000, 3'b000, LZC ? 1 : 6);
    pin("p_rndcarry", 0, 0, 0, 28'hFFFFFF8, 8'd127, 0,
        32'h40000000, 3'b001, 1);
    pin("p_ovf", 0, 0, 0, 28'h8000000, 8'd254, 1,
        32'h7F800000, 3'b100, 1);
    pin("p_special", 1, 32'h7FC00000, 0, 0, 0, 0,
        32'h7FC00000, 3'b000, 0);
    pin("p_subn", 0, 0, 0, 28'h0400001, 8'd2, 0,
        32'h00080000, 3'b011, LZC ? 1 : 3);
    pin("p_sub2norm", 0, 0, 0, 28'h7FFFFF8, 8'd1, 0,
        32'h00800000, 3'b001, LZC ? 1 : 2);
    pin("p_tie_even", 0, 0, 1, 28'h8000008, 8'd127, 0,
        32'hBF800000, 3'b001, 1);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", {61'd0, overflow, underflow, inexact}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);

    send(0, 0, 0, 28'h8000000, 8'd127, 1, 0);
    send(0, 0, 0, 28'h0000000, 8'd127, 1, 0);
    send(0, 0, 0, 28'h0800000, 8'd130, 0, 0);
    send(0, 0, 0, 28'hFFFFFF8, 8'd127, 0, 0);
    send(0, 0, 0, 28'h8000000, 8'd254, 1, 0);
    send(1, 32'h7FC00000, 0, 28'h0800000, 8'd9, 1, 0);
    send(0, 0, 1, 28'h0000000, 8'd50, 0, 0);
    send(0, 0, 0, 28'h0400001, 8'd2, 0, 0);
    send(0, 0, 0, 28'h7FFFFF8, 8'd1, 0, 0);
    send(0, 0, 1, 28'h8000008, 8'd127, 0, 0);
    send(0, 0, 0, 28'h800000C, 8'd100, 0, 0);
    send(0, 0, 0, 28'h0000001, 8'd200, 0, 0);
    send(0, 0, 0, 28'h0000000, 8'd127, 1, 3);

    exp_pending = 1'b0;
    special_in = 0; sign_in = 0; carry_in = 0;
    mant_in = 28'h0000100; exp_in = 8'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", 64'(result), 64'd0);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_idle", 64'(out_valid), 64'd0);
    send(0, 0, 0, 28'h0800000, 8'd130, 0, 0);

    for (int i = 0; i < 16; i++) begin
      rm = 28'($urandom) >> $urandom_range(0, 27);
      if (rm == 0) rm = 28'd1;
      send(0, 0, 1'($urandom), rm, 8'($urandom_range(2, 250)),
           1'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
